// File: rtl/mult_div_ctrl.sv
// mult_div_ctrl: multi-cycle MULT/DIV sequencer owning the HI/LO registers.
// Results are computed from operands captured at issue, held in pending
// registers, and committed to HI/LO when the busy countdown expires.
// Optional macro MD_DIVZERO_HOLD_EN: when defined, a divide by zero is not
// started at all (HI/LO untouched); otherwise it runs full length and
// commits LO=all-ones, HI=dividend.
module mult_div_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]   r_hi, w_hi_nxt;
  logic [DATA_W-1:0]   r_lo, w_lo_nxt;
  logic [DATA_W-1:0]   r_pend_hi, w_pend_hi_nxt;
  logic [DATA_W-1:0]   r_pend_lo, w_pend_lo_nxt;

  logic                w_is_mul;
  logic                w_is_div;
  logic                w_is_mthi;
  logic                w_is_mtlo;
  logic                w_div_zero;

  logic [2*DATA_W-1:0] w_rs_ext;
  logic [2*DATA_W-1:0] w_rt_ext;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_divisor;
  logic [DATA_W-1:0]   w_quo_s;
  logic [DATA_W-1:0]   w_rem_s;
  logic [DATA_W-1:0]   w_quo_u;
  logic [DATA_W-1:0]   w_rem_u;
  logic [DATA_W-1:0]   w_div_hi;
  logic [DATA_W-1:0]   w_div_lo;

  // Issue decode: start qualifies md_op.
  assign w_is_mul   = start & ((md_op == OP_MULT) | (md_op == OP_MULTU));
  assign w_is_div   = start & ((md_op == OP_DIV)  | (md_op == OP_DIVU));
  assign w_is_mthi  = start & (md_op == OP_MTHI);
  assign w_is_mtlo  = start & (md_op == OP_MTLO);
  assign w_div_zero = (rt_val == '0);

  // Product: low 64 bits of the extended operands give both signed and unsigned results.
  assign w_rs_ext = md_op[0] ? {{DATA_W{1'b0}}, rs_val} : {{DATA_W{rs_val[DATA_W-1]}}, rs_val};
  assign w_rt_ext = md_op[0] ? {{DATA_W{1'b0}}, rt_val} : {{DATA_W{rt_val[DATA_W-1]}}, rt_val};
  assign w_prod   = w_rs_ext * w_rt_ext;

  // Quotient/remainder; a zero divisor is replaced so the divider never sees it.
  assign w_divisor = w_div_zero ? DATA_W'(1) : rt_val;
  assign w_quo_s   = DATA_W'($signed(rs_val) / $signed(w_divisor));
  assign w_rem_s   = DATA_W'($signed(rs_val) % $signed(w_divisor));
  assign w_quo_u   = rs_val / w_divisor;
  assign w_rem_u   = rs_val % w_divisor;

  // Select signed/unsigned divide result, with the divide-by-zero fill.
  always_comb begin
    w_div_hi = md_op[0] ? w_rem_u : w_rem_s;
    w_div_lo = md_op[0] ? w_quo_u : w_quo_s;
    if (w_div_zero) begin
      w_div_hi = rs_val;
      w_div_lo = '1;
    end
  end

  // State register, counter, pending results and HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_hi      <= w_hi_nxt;
      r_lo      <= w_lo_nxt;
      r_pend_hi <= w_pend_hi_nxt;
      r_pend_lo <= w_pend_lo_nxt;
    end
  end

  // Next-state: issue from IDLE only; count down and commit on the last busy cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_hi_nxt      = r_hi;
    w_lo_nxt      = r_lo;
    w_pend_hi_nxt = r_pend_hi;
    w_pend_lo_nxt = r_pend_lo;
    case (r_state)
      ST_IDLE: begin
        if (w_is_mul) begin
          w_state_nxt   = ST_MUL;
          w_cnt_nxt     = CNT_W'(MULT_CYCLES);
          w_pend_hi_nxt = w_prod[2*DATA_W-1:DATA_W];
          w_pend_lo_nxt = w_prod[DATA_W-1:0];
        end else if (w_is_div) begin
`ifdef MD_DIVZERO_HOLD_EN
          if (!w_div_zero) begin
            w_state_nxt   = ST_DIV;
            w_cnt_nxt     = CNT_W'(DIV_CYCLES);
            w_pend_hi_nxt = w_div_hi;
            w_pend_lo_nxt = w_div_lo;
          end
`else
          w_state_nxt   = ST_DIV;
          w_cnt_nxt     = CNT_W'(DIV_CYCLES);
          w_pend_hi_nxt = w_div_hi;
          w_pend_lo_nxt = w_div_lo;
`endif
        end else if (w_is_mthi) begin
          w_hi_nxt = rs_val;
        end else if (w_is_mtlo) begin
          w_lo_nxt = rs_val;
        end
      end
      ST_MUL, ST_DIV: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_hi_nxt    = r_pend_hi;
          w_lo_nxt    = r_pend_lo;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs: busy/HI/LO come straight from registers; stall covers the issue cycle.
  assign busy     = (r_state != ST_IDLE);
  assign md_stall = md_use_D & (start | busy);
  assign hi       = r_hi;
  assign lo       = r_lo;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: HI/LO moves, MULT/MULTU/DIV/DIVU results,
// busy length, stall coverage, ignored mid-busy start, reset mid-op, divide by zero.
module tb_mult_div_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        md_use_D;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;

  mult_div_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_D (md_use_D),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle start pulse; operands are scrambled afterwards to catch re-sampling.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    #1;
    if (md_use_D) chk("stall_issue", 32'(md_stall), 32'd1);
    step();
    start  = 1'b0;
    md_op  = OP_NOP;
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  // Count busy cycles (bounded), optionally poking an illegal MTHI in cycle poke_at.
  task automatic wait_busy(input string tag, input int exp_n, input int poke_at,
                           input logic [31:0] hold_hi);
    int n  = 0;
    int ns = 0;
    while (busy && n < 40) begin
      n++;
      if (md_stall) ns++;
      if (n == poke_at) begin
        start  = 1'b1;
        md_op  = OP_MTHI;
        rs_val = 32'h0000_DEAD;
        step();
        start  = 1'b0;
        md_op  = OP_NOP;
        chk({tag, "_poke_hi"}, hi, hold_hi);
      end else begin
        step();
      end
    end
    chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    chk({tag, "_stall_cycles"}, 32'(ns), md_use_D ? 32'(exp_n) : 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = OP_NOP;
    rs_val   = '0;
    rt_val   = '0;
    md_use_D = 1'b0;
    step();
    step();

    // Reset values and combinational stall during reset
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    md_use_D = 1'b1;
    start    = 1'b1;
    #1;
    chk("rst_stall_start", 32'(md_stall), 32'd1);
    start = 1'b0;
    #1;
    chk("rst_stall_idle", 32'(md_stall), 32'd0);
    md_use_D = 1'b0;
    reset    = 1'b0;
    step();

    // MTHI / MTLO, one-cycle latency, no busy
    issue(OP_MTHI, 32'h0000_1234, 32'd0);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_busy", 32'(busy), 32'd0);
    issue(OP_MTLO, 32'h0000_ABCD, 32'd0);
    chk("mtlo_lo", lo, 32'h0000_ABCD);
    chk("mtlo_hi", hi, 32'h0000_1234);

    // MULT -3 * 5 with D-stage HI/LO user
    md_use_D = 1'b1;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    wait_busy("mult", 5, 0, 32'd0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);
    chk("mult_stall_after", 32'(md_stall), 32'd0);
    md_use_D = 1'b0;

    // MULTU back-to-back, issued in the first idle cycle
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_busy("multu", 5, 0, 32'd0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // DIV -7 / 2 with an ignored MTHI in busy cycle 3
    md_use_D = 1'b1;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_busy("div", 10, 3, 32'h0000_0001);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    md_use_D = 1'b0;

    // DIVU 7 / 2
    issue(OP_DIVU, 32'd7, 32'd2);
    wait_busy("divu", 10, 0, 32'd0);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    // DIV 7 / -2: quotient -3, remainder +1
    issue(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    wait_busy("divneg", 10, 0, 32'd0);
    chk("divneg_lo", lo, 32'hFFFF_FFFD);
    chk("divneg_hi", hi, 32'd1);

    // Reset in busy cycle 3 discards the in-flight divide
    issue(OP_DIV, 32'd100, 32'd7);
    step();
    step();
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_hi", hi, 32'd0);
    chk("rstmid_lo", lo, 32'd0);
    repeat (12) step();
    chk("rstmid_late_hi", hi, 32'd0);
    chk("rstmid_late_lo", lo, 32'd0);
    chk("rstmid_late_busy", 32'(busy), 32'd0);

    // Divide by zero
    issue(OP_MTHI, 32'h0000_0011, 32'd0);
    issue(OP_MTLO, 32'h0000_0022, 32'd0);
    issue(OP_DIV, 32'h0000_0055, 32'd0);
`ifdef MD_DIVZERO_HOLD_EN
    chk("divz_busy", 32'(busy), 32'd0);
    step();
    chk("divz_busy_later", 32'(busy), 32'd0);
    chk("divz_hi", hi, 32'h0000_0011);
    chk("divz_lo", lo, 32'h0000_0022);
`else
    wait_busy("divz", 10, 0, 32'd0);
    chk("divz_lo", lo, 32'hFFFF_FFFF);
    chk("divz_hi", hi, 32'h0000_0055);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_div_ctrl.md
# mult_div_ctrl

Multi-cycle multiply/divide sequencer for the five-stage MIPS pipeline. It owns the HI/LO registers and is driven from the E stage. It runs MULT/MULTU for a fixed number of cycles and DIV/DIVU for a longer fixed number, then commits HI/LO. While an operation is in flight, or starting, it raises a stall request for the hazard logic whenever the D-stage instruction uses HI/LO.

## Interface
Parameters:
- MULT_CYCLES, default 5: busy cycles for MULT/MULTU; legal range 1–15.
- DIV_CYCLES, default 10: busy cycles for DIV/DIVU; legal range 1–15.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  synchronous, active-high.
- start  input  1  E-stage instruction is a HI/LO op; qualifies md_op.
- md_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- rs_val  input  32  forwarded rs operand from the E stage.
- rt_val  input  32  forwarded rt operand from the E stage.
- md_use_D  input  1  D-stage instruction is MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
- busy  output  1  operation in flight.
- md_stall  output  1  stall request to the hazard unit: md_use_D & (start | busy).
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

## Operation
- FSM states:
  - IDLE → MUL when start & md_op∈{MULT,MULTU}; the counter loads MULT_CYCLES.
  - IDLE → DIV when start & md_op∈{DIV,DIVU}; the counter loads DIV_CYCLES.
  - MUL/DIV: the counter decrements each cycle. At the edge where the count reaches 1, the FSM returns to IDLE and pending results are written to HI/LO.
- Results are computed from rs_val/rt_val sampled at the start edge and held in internal pend_hi/pend_lo registers. Operands are not re-sampled during the operation.
  - MULT: signed 64-bit product; MULTU: unsigned; HI = [63:32], LO = [31:0].
  - DIV: LO = signed quotient, truncated toward zero; HI = remainder with the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero: see Configuration.
- MTHI/MTLO: while IDLE, HI (or LO) takes rs_val at the next edge. No busy cycle.
- start while busy is a protocol violation that md_stall prevents. The block ignores it, including MTHI/MTLO, and leaves state and counter unchanged.
- md_stall is combinational. It covers the issue cycle (start=1) so a following MFHI/MFLO or mult/div cannot slip past.
- Reset clears HI, LO, pending registers and counter, and returns to IDLE. This includes reset mid-operation: the in-flight result is discarded.

## Timing
- Reset values: busy=0, md_stall=md_use_D&start (combinational), hi=0, lo=0.
- Edge 0 samples start; busy=1 from cycle 1 through cycle N, where N = MULT_CYCLES or DIV_CYCLES.
- HI/LO are updated at the edge ending cycle N. The new values are visible and busy=0 in cycle N+1.
- Back-to-back ops:
  - A new start is accepted in cycle N+1; there is no dead cycle.
  - A start in the same cycle as completion is not possible, because busy=1 in cycle N.
- MTHI/MTLO have 1-cycle latency.
- Counter is 4 bits.

## Configuration
- MD_DIVZERO_HOLD_EN:
  - Defined: DIV/DIVU with rt_val=0 does not enter DIV state. busy stays 0 and HI/LO are unchanged.
  - Undefined: divide by zero runs the full DIV_CYCLES and commits LO=32'hFFFF_FFFF, HI=rs_val, for both signed and unsigned.

## Test plan
- Reset → busy=0, hi=0, lo=0; then MTHI 0x1234 and MTLO 0xABCD → hi=0x00001234, lo=0x0000ABCD one cycle later.
- MULT rs=-3, rt=5 → busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1; MULTU 0xFFFFFFFF×2 → hi=1, lo=0xFFFFFFFE.
- DIV rs=-7, rt=2 → busy high for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 → lo=3, hi=1.
- md_use_D=1 during the start cycle and all busy cycles → md_stall=1 for 1+N cycles, then 0; start pulsed mid-busy → hi/lo unchanged.
- Reset asserted in busy cycle 3 of a DIV → busy=0 next cycle, hi=lo=0, no later commit.
- DIV rt=0 with prior hi=0x11, lo=0x22:
  - With MD_DIVZERO_HOLD_EN: busy stays 0, hi/lo unchanged.
  - Without it: after 10 cycles lo=0xFFFFFFFF, hi=rs_val.
